prime_scan_engine: RTL and testbench
====================================

# prime_scan_engine

Parametrised successor to the fixed-range prime lookup counter. The block scans every candidate `n` in `2 .. num_max-1` and decides primality arithmetically by trial division, so it has no lookup table and works at any width `W`. Primes are streamed out over a valid/ready handshake, and the block keeps a running count. It sits under the exercise top level as the generic prime source for display and counter logic.

## Interface
- `W`, default 11: width of candidates, `num_max`, counters and `prime_out`.
- `clk` input, 1 bit: clock; all state changes on rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a scan; accepted only in IDLE.
- `num_max` input, W bits: exclusive upper bound; sampled when `start` is accepted.
- `busy` output, 1 bit: high in every state except IDLE and DONE.
- `done` output, 1 bit: one-cycle pulse at scan end.
- `prime_valid` output, 1 bit: `prime_out` holds a prime.
- `prime_ready` input, 1 bit: consumer accepts `prime_out`.
- `prime_out` output, W bits: current prime.
- `number_checked` output, W bits: candidate currently under test.
- `number_of_primes` output, W bits: primes handed off this scan.

## Operation
- Reset (asynchronous, `rst`=0):
  - state = IDLE.
  - All outputs = 0.
  - All internal registers (`n`, `d`, `r`, bit counter, captured max) = 0.
- IDLE:
  - On `start`=1: capture `num_max` into `max_q`; clear `number_of_primes` and `number_checked`; set `n`=2.
  - If `num_max` <= 2, go to DONE; otherwise go to LOAD.
- LOAD:
  - `number_checked` <= `n`; `d` <= 2.
  - Go to TRIAL.
- TRIAL:
  - Compute `d*d` at 2W bits; it must not wrap.
  - If `d*d` > `n`: the candidate is prime; `prime_out` <= `n`, `prime_valid` <= 1, go to EMIT.
  - Otherwise: `r` <= 0, bit index <= W-1, go to DIV.
- DIV: restoring remainder, one bit of `n` per cycle, MSB first, W cycles in total.
  - `t` = {`r`, `n[idx]`}, held in W+1 bits.
  - `r` <= (`t` >= `d`) ? `t`-`d` : `t`.
  - After the idx=0 step, go to TEST. At that point `r` = `n mod d`.
- TEST:
  - If `r`==0: the candidate is composite; go to NEXT.
  - Otherwise: `d` <= `d`+1; go to TRIAL.
- EMIT:
  - Hold `prime_valid`=1 and a stable `prime_out` until a cycle with `prime_ready`=1.
  - In that handshake cycle: `number_of_primes` += 1, `prime_valid` <= 0, go to NEXT.
- NEXT:
  - `n` <= `n`+1.
  - If `n`+1 >= `max_q`, go to DONE; otherwise go to LOAD.
- DONE:
  - `done`=1 for exactly one cycle; go to IDLE.
- Output retention: `number_of_primes`, `number_checked` and `prime_out` hold their last values in IDLE until the next accepted `start`.
- `start` is ignored in every state other than IDLE; it has no effect while `busy` is high.
- Width rules:
  - `n` < 2^W, so `number_of_primes` cannot overflow.
  - `d` never exceeds floor(sqrt(2^W))+1.
  - `n+1` is compared at W+1 bits, so `num_max` = 2^W-1 terminates correctly.
- Reset mid-scan: the next edge after reset release sees IDLE with all outputs 0. No partial count survives, and no stale `prime_valid` remains.

## Timing
- The `start` accept cycle is cycle 0. `busy` rises at cycle 1 if `num_max` > 2.
- Composite candidate whose smallest factor is the k-th trial divisor (`d`=k+1): 1 + k·(W+2) + 1 cycles (LOAD … NEXT).
- Prime candidate tested with k divisors and zero stall: 1 + k·(W+2) + 1 + 1 + 1 cycles (LOAD, k·(TRIAL+DIV+TEST), final TRIAL, EMIT, NEXT). Each cycle of `prime_ready`=0 adds one cycle.
- Specific costs:
  - `n`=2 or 3: 4 cycles.
  - `n`=4: W+4 cycles.
- `prime_valid` rises the cycle after the deciding TRIAL and falls the cycle after the handshake. It never asserts for a composite and never asserts twice for the same `n`.
- `done` is high one cycle after the final NEXT. For `num_max` <= 2, `done` is high at cycle 1 with count 0.

## Test plan
- W=11, `num_max`=11, `prime_ready`=1: primes 2,3,5,7 in order; `done` pulses once; `number_of_primes`=4; `number_checked`=10.
- W=11, `num_max`=1000: 168 handshakes; the last `prime_out`=997; `number_of_primes`=168.
- Backpressure, `num_max`=11: `prime_ready`=0 for 5 cycles at the first valid. Then `prime_out`=2 stays stable for 6 cycles, `number_of_primes` stays 0 until the handshake, and final results match the first case.
- `num_max`=2 and `num_max`=0: `done` at cycle 1, count 0, `prime_valid` never asserted; a `start` while `busy` is high has no effect.
- Cycle check with W=11, `num_max`=5: candidate 4 spans 15 cycles from LOAD to NEXT; candidate 2 gives `prime_valid` at cycle 3 after `start`.
- Assert `rst`=0 mid-DIV on `num_max`=100: all outputs 0 immediately. A new `start` with `num_max`=20 yields 8 primes.

Source files
------------

// File: rtl/prime_scan_engine_if.sv
// Control and result bundle for prime_scan_engine: scan request in,
// prime stream (valid/ready) and progress counters out.
interface prime_scan_engine_if #(
    parameter int W = 11
) ();
    logic         start;
    logic [W-1:0] num_max;
    logic         busy;
    logic         done;
    logic         prime_valid;
    logic         prime_ready;
    logic [W-1:0] prime_out;
    logic [W-1:0] number_checked;
    logic [W-1:0] number_of_primes;

    modport master (
        output start, num_max, prime_ready,
        input  busy, done, prime_valid, prime_out, number_checked, number_of_primes
    );

    modport slave (
        input  start, num_max, prime_ready,
        output busy, done, prime_valid, prime_out, number_checked, number_of_primes
    );
endinterface

// File: rtl/prime_scan_engine.sv
// Scans 2..num_max-1 and streams every prime found, deciding primality by
// trial division with a bit-serial restoring remainder (one bit per cycle).
module prime_scan_engine #(
    parameter int W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    prime_scan_engine_if.slave    bus
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TRIAL,
        S_DIV,
        S_TEST,
        S_EMIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;

    logic [W-1:0]   n_q;
    logic [W-1:0]   d_q;
    logic [W-1:0]   r_q;
    logic [IW-1:0]  idx_q;
    logic [W-1:0]   max_q;

    logic [W-1:0]   prime_out_q;
    logic           prime_valid_q;
    logic [W-1:0]   checked_q;
    logic [W-1:0]   count_q;

    // Datapath terms shared by the FSM and the register update.
    logic [2*W-1:0] d_sq;
    logic           d_sq_gt_n;
    logic [W:0]     t;
    logic           t_ge_d;
    logic [W-1:0]   t_sub;
    logic [W-1:0]   r_step;
    logic [W:0]     n_plus1;
    logic           last_cand;

    always_comb begin
        d_sq      = {{W{1'b0}}, d_q} * {{W{1'b0}}, d_q};
        d_sq_gt_n = d_sq > {{W{1'b0}}, n_q};
        t         = {r_q, n_q[idx_q]};
        t_ge_d    = t >= {1'b0, d_q};
        // t - d < d whenever it is taken, so the low W bits carry the full result.
        t_sub     = t[W-1:0] - d_q;
        r_step    = t_ge_d ? t_sub : t[W-1:0];
        n_plus1   = {1'b0, n_q} + {{W{1'b0}}, 1'b1};
        last_cand = n_plus1 >= {1'b0, max_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.num_max <= W'(2)) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                bus.busy = 1'b1;
                state_d  = S_TRIAL;
            end
            S_TRIAL: begin
                bus.busy = 1'b1;
                state_d  = d_sq_gt_n ? S_EMIT : S_DIV;
            end
            S_DIV: begin
                bus.busy = 1'b1;
                if (idx_q == '0) begin
                    state_d = S_TEST;
                end
            end
            S_TEST: begin
                bus.busy = 1'b1;
                state_d  = (r_q == '0) ? S_NEXT : S_TRIAL;
            end
            S_EMIT: begin
                bus.busy = 1'b1;
                if (bus.prime_ready) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                bus.busy = 1'b1;
                state_d  = last_cand ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q           <= '0;
            d_q           <= '0;
            r_q           <= '0;
            idx_q         <= '0;
            max_q         <= '0;
            prime_out_q   <= '0;
            prime_valid_q <= 1'b0;
            checked_q     <= '0;
            count_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        max_q     <= bus.num_max;
                        count_q   <= '0;
                        checked_q <= '0;
                        n_q       <= W'(2);
                    end
                end
                S_LOAD: begin
                    checked_q <= n_q;
                    d_q       <= W'(2);
                end
                S_TRIAL: begin
                    if (d_sq_gt_n) begin
                        prime_out_q   <= n_q;
                        prime_valid_q <= 1'b1;
                    end else begin
                        r_q   <= '0;
                        idx_q <= IW'(W - 1);
                    end
                end
                S_DIV: begin
                    r_q   <= r_step;
                    idx_q <= idx_q - IW'(1);
                end
                S_TEST: begin
                    if (r_q != '0) begin
                        d_q <= d_q + W'(1);
                    end
                end
                S_EMIT: begin
                    if (bus.prime_ready) begin
                        count_q       <= count_q + W'(1);
                        prime_valid_q <= 1'b0;
                    end
                end
                S_NEXT: begin
                    n_q <= n_plus1[W-1:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.prime_out        = prime_out_q;
    assign bus.prime_valid      = prime_valid_q;
    assign bus.number_checked   = checked_q;
    assign bus.number_of_primes = count_q;

endmodule

// File: tb/tb_prime_scan_engine.sv
// Directed bench for prime_scan_engine: expected primes are queued at each
// start and a negedge monitor pops and compares them on every handshake.
module tb_prime_scan_engine;

    localparam int W = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    prime_scan_engine_if #(.W(W)) bus ();

    prime_scan_engine #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           checks     = 0;
    int           errors     = 0;
    int           done_cnt   = 0;
    int           handshakes = 0;
    logic [W-1:0] last_out   = '0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_prime(input int v);
        if (v < 2) return 1'b0;
        for (int k = 2; k * k <= v; k++) begin
            if (v % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Scoreboard monitor: one comparison per accepted prime.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.done) done_cnt++;
            if (bus.prime_valid && bus.prime_ready) begin
                handshakes++;
                last_out = bus.prime_out;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_prime: got %0d, expected no handshake", bus.prime_out);
                end else begin
                    check("prime_out", bus.prime_out, exp_q.pop_front());
                end
            end
        end
    end

    // Pulses start for one cycle; returns just after the accept edge (cycle 0).
    task automatic do_start(input int mx, input bit expect_primes);
        @(posedge clk);
        #1;
        bus.num_max = W'(mx);
        bus.start   = 1'b1;
        if (expect_primes) begin
            for (int v = 2; v < mx; v++) begin
                if (is_prime(v)) exp_q.push_back(W'(v));
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        check("done_timeout", {31'b0, bus.done}, 1);
    endtask

    initial begin
        int c, cv, c4, cd, hs0;

        bus.start       = 1'b0;
        bus.num_max     = '0;
        bus.prime_ready = 1'b1;

        // Reset state
        #12;
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_done", {31'b0, bus.done}, 0);
        check("rst_valid", {31'b0, bus.prime_valid}, 0);
        check("rst_prime_out", bus.prime_out, 0);
        check("rst_checked", bus.number_checked, 0);
        check("rst_count", bus.number_of_primes, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // num_max = 11, no backpressure: 2,3,5,7
        do_start(11, 1'b1);
        @(negedge clk);
        check("t1_busy_cycle1", {31'b0, bus.busy}, 1);
        wait_done(2000);
        check("t1_busy_at_done", {31'b0, bus.busy}, 0);
        check("t1_count", bus.number_of_primes, 4);
        check("t1_checked", bus.number_checked, 10);
        check("t1_queue_left", exp_q.size(), 0);
        @(negedge clk);
        check("t1_done_one_cycle", {31'b0, bus.done}, 0);
        check("t1_count_held", bus.number_of_primes, 4);

        // num_max = 5: valid at cycle 3, candidate 4 spans W+4 = 15 cycles
        do_start(5, 1'b1);
        c = 0; cv = -1; c4 = -1; cd = -1;
        while (cd < 0 && c < 500) begin
            @(negedge clk);
            c++;
            if (bus.prime_valid && cv < 0) cv = c;
            if (bus.number_checked == W'(4) && c4 < 0) c4 = c;
            if (bus.done) cd = c;
        end
        check("t2_valid_cycle", cv, 3);
        check("t2_cand4_span", cd - c4 + 1, 15);
        check("t2_done_cycle", cd, 24);
        check("t2_count", bus.number_of_primes, 2);

        // Backpressure: ready low for 5 cycles at the first valid
        @(posedge clk);
        #1;
        bus.prime_ready = 1'b0;
        do_start(11, 1'b1);
        c = 0;
        while (!bus.prime_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("t3_valid_cycle", c, 3);
        for (int i = 0; i < 6; i++) begin
            check("t3_hold_valid", {31'b0, bus.prime_valid}, 1);
            check("t3_hold_out", bus.prime_out, 2);
            check("t3_hold_count", bus.number_of_primes, 0);
            if (i < 5) begin
                if (i == 4) begin
                    @(posedge clk);
                    #1;
                    bus.prime_ready = 1'b1;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        check("t3_count_after_hs", bus.number_of_primes, 1);
        check("t3_valid_dropped", {31'b0, bus.prime_valid}, 0);
        wait_done(2000);
        check("t3_count", bus.number_of_primes, 4);
        check("t3_checked", bus.number_checked, 10);
        check("t3_queue_left", exp_q.size(), 0);

        // num_max = 2 and 0: immediate done, nothing emitted
        do_start(2, 1'b0);
        @(negedge clk);
        check("t4_done_cycle1", {31'b0, bus.done}, 1);
        check("t4_busy", {31'b0, bus.busy}, 0);
        check("t4_count", bus.number_of_primes, 0);
        check("t4_checked", bus.number_checked, 0);
        check("t4_valid", {31'b0, bus.prime_valid}, 0);
        do_start(0, 1'b0);
        @(negedge clk);
        check("t5_done_cycle1", {31'b0, bus.done}, 1);
        check("t5_count", bus.number_of_primes, 0);

        // num_max = 1000 with a stray start while busy
        hs0 = handshakes;
        do_start(1000, 1'b1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        bus.num_max = W'(5);
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("t6_busy_after_stray_start", {31'b0, bus.busy}, 1);
        wait_done(90000);
        check("t6_count", bus.number_of_primes, 168);
        check("t6_handshakes", handshakes - hs0, 168);
        check("t6_last_prime", last_out, 997);
        check("t6_checked", bus.number_checked, 999);
        check("t6_queue_left", exp_q.size(), 0);

        // Reset in the middle of DIV on candidate 4, then a fresh scan
        do_start(100, 1'b1);
        c = 0;
        while (bus.number_checked != W'(4) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("t7_reached_cand4", bus.number_checked, 4);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t7_rst_busy", {31'b0, bus.busy}, 0);
        check("t7_rst_valid", {31'b0, bus.prime_valid}, 0);
        check("t7_rst_prime_out", bus.prime_out, 0);
        check("t7_rst_checked", bus.number_checked, 0);
        check("t7_rst_count", bus.number_of_primes, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("t7_idle_after_rst", {31'b0, bus.busy}, 0);
        do_start(20, 1'b1);
        wait_done(5000);
        check("t7_count", bus.number_of_primes, 8);
        check("t7_queue_left", exp_q.size(), 0);

        repeat (2) @(negedge clk);
        check("done_pulses", done_cnt, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
